// File: rtl/mdio_responder.sv
// PHY-side Clause-22 MDIO responder, clocked directly by MDC.
// Decodes frames, strobes a local register file and shifts read data back out via out/oe.
module mdio_responder #(
    parameter logic [4:0] PHY_ADDRESS  = 5'd1,
    parameter int         PREAMBLE_MIN = 32,
    parameter logic [1:0] READ         = 2'b10,
    parameter logic [1:0] WRITE        = 2'b01
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [4:0]  reg_address,
    output logic        reg_read,
    input  logic [15:0] reg_rdata,
    output logic        reg_write,
    output logic [15:0] reg_wdata,
    output logic        busy,
    output logic        frame_error
);
    typedef enum logic [2:0] {
        S_HUNT, S_START, S_OPCODE, S_PHY_ADDR, S_REG_ADDR, S_TURNAROUND, S_DATA
    } state_t;

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

    state_t      r_state, w_state_nx;
    logic [5:0]  r_ones, w_ones_nx;
    logic [3:0]  r_bit_cnt, w_bit_cnt_nx;
    logic [15:0] r_shift, w_shift_nx;
    logic        r_is_read, w_is_read_nx;

    logic        r_mdio_out, w_mdio_out_nx;
    logic        r_mdio_oe, w_mdio_oe_nx;
    logic [4:0]  r_reg_address, w_reg_address_nx;
    logic        r_reg_read, w_reg_read_nx;
    logic        r_reg_write, w_reg_write_nx;
    logic [15:0] r_reg_wdata, w_reg_wdata_nx;
    logic        r_busy, w_busy_nx;
    logic        r_frame_error, w_frame_error_nx;

    logic [15:0] w_shift_in;
    logic [1:0]  w_opcode;
    logic [4:0]  w_addr5;
    logic        w_op_ok;
    logic        w_preamble_ok;

    // Serial fields are assembled MSB first; the newest bit is always the LSB.
    assign w_shift_in    = {r_shift[14:0], mdio_in};
    assign w_opcode      = w_shift_in[1:0];
    assign w_addr5       = w_shift_in[4:0];
    assign w_op_ok       = (w_opcode == READ) || (w_opcode == WRITE);
    assign w_preamble_ok = (r_ones >= PRE_MIN);

    // State register plus datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_HUNT;
            r_ones        <= 6'd0;
            r_bit_cnt     <= 4'd0;
            r_shift       <= 16'd0;
            r_is_read     <= 1'b0;
            r_mdio_out    <= 1'b1;
            r_mdio_oe     <= 1'b0;
            r_reg_address <= 5'd0;
            r_reg_read    <= 1'b0;
            r_reg_write   <= 1'b0;
            r_reg_wdata   <= 16'd0;
            r_busy        <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_ones        <= w_ones_nx;
            r_bit_cnt     <= w_bit_cnt_nx;
            r_shift       <= w_shift_nx;
            r_is_read     <= w_is_read_nx;
            r_mdio_out    <= w_mdio_out_nx;
            r_mdio_oe     <= w_mdio_oe_nx;
            r_reg_address <= w_reg_address_nx;
            r_reg_read    <= w_reg_read_nx;
            r_reg_write   <= w_reg_write_nx;
            r_reg_wdata   <= w_reg_wdata_nx;
            r_busy        <= w_busy_nx;
            r_frame_error <= w_frame_error_nx;
        end
    end

    // Next-state: frame field sequencing, preamble counting and the shift register.
    always_comb begin
        w_state_nx   = r_state;
        w_ones_nx    = 6'd0;
        w_bit_cnt_nx = r_bit_cnt + 4'd1;
        w_shift_nx   = w_shift_in;
        w_is_read_nx = r_is_read;
        case (r_state)
            S_HUNT: begin
                w_bit_cnt_nx = 4'd0;
                if (mdio_in) begin
                    w_ones_nx = (r_ones == 6'd63) ? 6'd63 : r_ones + 6'd1;
                end else begin
                    w_state_nx = w_preamble_ok ? S_START : S_HUNT;
                end
            end
            S_START: begin
                w_bit_cnt_nx = 4'd0;
                w_state_nx   = mdio_in ? S_OPCODE : S_HUNT;
            end
            S_OPCODE: begin
                if (r_bit_cnt == 4'd1) begin
                    w_bit_cnt_nx = 4'd0;
                    w_is_read_nx = (w_opcode == READ);
                    w_state_nx   = w_op_ok ? S_PHY_ADDR : S_HUNT;
                end else begin
                    w_state_nx = S_OPCODE;
                end
            end
            S_PHY_ADDR: begin
                if (r_bit_cnt == 4'd4) begin
                    w_bit_cnt_nx = 4'd0;
                    w_state_nx   = (w_addr5 == PHY_ADDRESS) ? S_REG_ADDR : S_HUNT;
                end else begin
                    w_state_nx = S_PHY_ADDR;
                end
            end
            S_REG_ADDR: begin
                if (r_bit_cnt == 4'd4) begin
                    w_bit_cnt_nx = 4'd0;
                    w_state_nx   = S_TURNAROUND;
                end else begin
                    w_state_nx = S_REG_ADDR;
                end
            end
            S_TURNAROUND: begin
                // Read data is captured on the first TA edge, one cycle after the read strobe.
                if (r_is_read) begin
                    w_shift_nx = (r_bit_cnt == 4'd0) ? reg_rdata : {r_shift[14:0], 1'b0};
                end else begin
                    w_shift_nx = w_shift_in;
                end
                if (r_bit_cnt == 4'd1) begin
                    w_bit_cnt_nx = 4'd0;
                    w_state_nx   = S_DATA;
                end else begin
                    w_state_nx = S_TURNAROUND;
                end
            end
            S_DATA: begin
                w_shift_nx = r_is_read ? {r_shift[14:0], 1'b0} : w_shift_in;
                w_state_nx = (r_bit_cnt == 4'd15) ? S_HUNT : S_DATA;
            end
            default: begin
                w_bit_cnt_nx = 4'd0;
                w_state_nx   = S_HUNT;
            end
        endcase
    end

    // Output next-values: strobes default low, levels hold unless a field boundary changes them.
    always_comb begin
        w_mdio_oe_nx      = r_mdio_oe;
        w_mdio_out_nx     = r_mdio_out;
        w_reg_read_nx     = 1'b0;
        w_reg_write_nx    = 1'b0;
        w_reg_wdata_nx    = r_reg_wdata;
        w_reg_address_nx  = r_reg_address;
        w_busy_nx         = r_busy;
        w_frame_error_nx  = 1'b0;
        case (r_state)
            S_HUNT: begin
                w_busy_nx = ~mdio_in & w_preamble_ok;
            end
            S_START: begin
                w_frame_error_nx = ~mdio_in;
                w_busy_nx        = mdio_in;
            end
            S_OPCODE: begin
                if ((r_bit_cnt == 4'd1) && !w_op_ok) begin
                    w_frame_error_nx = 1'b1;
                    w_busy_nx        = 1'b0;
                end else begin
                    w_busy_nx = 1'b1;
                end
            end
            S_PHY_ADDR: begin
                if ((r_bit_cnt == 4'd4) && (w_addr5 != PHY_ADDRESS)) begin
                    w_frame_error_nx = 1'b1;
                    w_busy_nx        = 1'b0;
                end else begin
                    w_busy_nx = 1'b1;
                end
            end
            S_REG_ADDR: begin
                if (r_bit_cnt == 4'd4) begin
                    w_reg_address_nx = w_addr5;
                    w_reg_read_nx    = r_is_read;
                end else begin
                    w_reg_address_nx = r_reg_address;
                end
            end
            S_TURNAROUND: begin
                if (r_is_read) begin
                    w_mdio_oe_nx  = 1'b1;
                    w_mdio_out_nx = (r_bit_cnt == 4'd0) ? 1'b0 : r_shift[15];
                end else begin
                    w_mdio_oe_nx  = 1'b0;
                    w_mdio_out_nx = 1'b1;
                end
            end
            S_DATA: begin
                if (r_bit_cnt == 4'd15) begin
                    w_mdio_oe_nx   = 1'b0;
                    w_mdio_out_nx  = 1'b1;
                    w_busy_nx      = 1'b0;
                    w_reg_write_nx = ~r_is_read;
                    w_reg_wdata_nx = r_is_read ? r_reg_wdata : w_shift_in;
                end else begin
                    w_mdio_out_nx = r_is_read ? r_shift[15] : 1'b1;
                end
            end
            default: begin
                w_mdio_oe_nx  = 1'b0;
                w_mdio_out_nx = 1'b1;
                w_busy_nx     = 1'b0;
            end
        endcase
    end

    assign mdio_out    = r_mdio_out;
    assign mdio_oe     = r_mdio_oe;
    assign reg_address = r_reg_address;
    assign reg_read    = r_reg_read;
    assign reg_write   = r_reg_write;
    assign reg_wdata   = r_reg_wdata;
    assign busy        = r_busy;
    assign frame_error = r_frame_error;
endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: a frame-level model predicts every output per cycle from the
// driven bit stream; directed frames pin the model, then randomized frame mixes follow.
module tb_mdio_responder;
    localparam int         MAXN = 2048;
    localparam int         PRE  = 32;
    localparam logic [4:0] PHY  = 5'd1;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mdio_in = 1'b1;
    logic [15:0] reg_rdata = 16'd0;
    logic        mdio_out, mdio_oe, reg_read, reg_write, busy, frame_error;
    logic [4:0]  reg_address;
    logic [15:0] reg_wdata;

    mdio_responder dut (
        .clock(clock), .reset(reset), .mdio_in(mdio_in),
        .mdio_out(mdio_out), .mdio_oe(mdio_oe), .reg_address(reg_address),
        .reg_read(reg_read), .reg_rdata(reg_rdata), .reg_write(reg_write),
        .reg_wdata(reg_wdata), .busy(busy), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    // Stimulus stream and per-cycle expectations (value after the posedge sampling s[t]).
    logic        s     [0:MAXN+63];
    logic [15:0] rd    [0:MAXN+63];
    logic        e_oe  [0:MAXN+63];
    logic        e_out [0:MAXN+63];
    logic        e_rd  [0:MAXN+63];
    logic        e_wr  [0:MAXN+63];
    logic        e_busy[0:MAXN+63];
    logic        e_ferr[0:MAXN+63];
    logic [4:0]  e_addr[0:MAXN+63];
    logic [15:0] e_wdata[0:MAXN+63];
    int          n = 0;
    logic        use_fixed = 1'b0;
    logic [15:0] fixed_rd = 16'd0;

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;
    int cur   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic push_bit(input logic b);
        s[n]  = b;
        rd[n] = use_fixed ? fixed_rd : 16'($urandom);
        n++;
    endtask

    task automatic push_field(input logic [15:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) push_bit(v[i]);
    endtask

    task automatic push_frame(input int pre, input logic st1, input logic [1:0] op,
                              input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] d);
        for (int i = 0; i < pre; i++) push_bit(1'b1);
        push_bit(1'b0);
        push_bit(st1);
        push_field({14'd0, op}, 2);
        push_field({11'd0, pa}, 5);
        push_field({11'd0, ra}, 5);
        push_field(16'h0002, 2);
        push_field(d, 16);
    endtask

    // Frame-level parse of the whole stream; anything past n is simply not observed.
    task automatic build_model();
        int p, ones, st, p0;
        logic [1:0]  op;
        logic [4:0]  pa, ra;
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            e_oe[i] = 1'b0; e_out[i] = 1'b1; e_rd[i] = 1'b0; e_wr[i] = 1'b0;
            e_busy[i] = 1'b0; e_ferr[i] = 1'b0; e_addr[i] = 5'd0; e_wdata[i] = 16'd0;
        end
        p = 0; ones = 0;
        while (p < n) begin
            if (s[p] == 1'b1) begin
                ones = (ones < 63) ? ones + 1 : 63;
                p++;
            end else if (ones < PRE) begin
                ones = 0;
                p++;
            end else begin
                st = p; ones = 0;
                if (s[p+1] !== 1'b1) begin
                    for (int i = st; i <= p && i < n; i++) e_busy[i] = 1'b1;
                    if (p + 1 < n) e_ferr[p+1] = 1'b1;
                    p += 2;
                end else begin
                    op = {s[p+2], s[p+3]};
                    if (op != OP_RD && op != OP_WR) begin
                        for (int i = st; i <= p + 2 && i < n; i++) e_busy[i] = 1'b1;
                        if (p + 3 < n) e_ferr[p+3] = 1'b1;
                        p += 4;
                    end else begin
                        for (int k = 0; k < 5; k++) pa[4-k] = s[p+4+k];
                        if (pa != PHY) begin
                            for (int i = st; i <= p + 7 && i < n; i++) e_busy[i] = 1'b1;
                            if (p + 8 < n) e_ferr[p+8] = 1'b1;
                            p += 9;
                        end else begin
                            for (int k = 0; k < 5; k++) ra[4-k] = s[p+9+k];
                            p0 = p + 13;
                            for (int i = p0; i < n; i++) e_addr[i] = ra;
                            for (int i = st; i <= p0 + 17 && i < n; i++) e_busy[i] = 1'b1;
                            if (op == OP_RD) begin
                                if (p0 < n) e_rd[p0] = 1'b1;
                                d = rd[p0+1];
                                for (int i = p0 + 1; i <= p0 + 17 && i < n; i++) e_oe[i] = 1'b1;
                                if (p0 + 1 < n) e_out[p0+1] = 1'b0;
                                for (int k = 0; k < 16; k++)
                                    if (p0 + 2 + k < n) e_out[p0+2+k] = d[15-k];
                            end else begin
                                for (int k = 0; k < 16; k++) d[15-k] = s[p0+3+k];
                                if (p0 + 18 < n) e_wr[p0+18] = 1'b1;
                                for (int i = p0 + 18; i < n; i++) e_wdata[i] = d;
                            end
                            p = p0 + 19;
                        end
                    end
                end
            end
        end
    endtask

    task automatic count_model(output int c_rd, output int c_wr, output int c_fe, output int c_oe);
        c_rd = 0; c_wr = 0; c_fe = 0; c_oe = 0;
        for (int i = 0; i < n; i++) begin
            c_rd += int'(e_rd[i]); c_wr += int'(e_wr[i]);
            c_fe += int'(e_ferr[i]); c_oe += int'(e_oe[i]);
        end
    endtask

    task automatic run_segment();
        build_model();
        for (int t = 0; t < n; t++) begin
            mdio_in   = s[t];
            reg_rdata = rd[t];
            @(posedge clock);
            #1;
            cur  = t;
            mode = 1;
        end
    endtask

    task automatic do_reset();
        mdio_in = 1'b1;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        mode  = 2;
        reset = 1'b0;
    endtask

    // Single compare process: model on frame cycles, reset values after a reset edge.
    always @(negedge clock) begin
        if (mode == 1) begin
            n_cmp++;
            if ({mdio_oe, mdio_out, reg_read, reg_write, busy, frame_error, reg_address, reg_wdata} !==
                {e_oe[cur], e_out[cur], e_rd[cur], e_wr[cur], e_busy[cur], e_ferr[cur], e_addr[cur], e_wdata[cur]}) begin
                n_bad++;
                $display("FAIL cycle[%0d] got oe=%b out=%b rd=%b wr=%b busy=%b ferr=%b addr=%0d wdata=%h required oe=%b out=%b rd=%b wr=%b busy=%b ferr=%b addr=%0d wdata=%h",
                         cur, mdio_oe, mdio_out, reg_read, reg_write, busy, frame_error, reg_address, reg_wdata,
                         e_oe[cur], e_out[cur], e_rd[cur], e_wr[cur], e_busy[cur], e_ferr[cur], e_addr[cur], e_wdata[cur]);
            end
        end else if (mode == 2) begin
            n_cmp++;
            if ({mdio_oe, mdio_out, reg_read, reg_write, busy, frame_error, reg_address, reg_wdata} !==
                {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0}) begin
                n_bad++;
                $display("FAIL reset_state got oe=%b out=%b rd=%b wr=%b busy=%b ferr=%b addr=%0d wdata=%h",
                         mdio_oe, mdio_out, reg_read, reg_write, busy, frame_error, reg_address, reg_wdata);
            end
        end
    end

    task automatic random_segment();
        int nz, pre, sel;
        logic [1:0] op;
        logic [4:0] pa;
        n = 0;
        for (int f = 0; f < 5; f++) begin
            nz = $urandom_range(0, 4);
            for (int i = 0; i < nz; i++) push_bit(1'($urandom_range(0, 1)));
            pre = $urandom_range(28, 45);
            sel = $urandom_range(0, 9);
            op  = (sel == 0) ? 2'b11 : (sel == 1) ? 2'b00 : ($urandom_range(0, 1) == 0) ? OP_RD : OP_WR;
            pa  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : PHY;
            push_frame(pre, ($urandom_range(0, 9) != 0), op, pa, 5'($urandom), 16'($urandom));
        end
        for (int i = 0; i < 3; i++) push_bit(1'b1);
        if ($urandom_range(0, 2) == 0) n = $urandom_range(n / 2, n - 1);
        run_segment();
        do_reset();
    endtask

    initial begin
        int c_rd, c_wr, c_fe, c_oe;
        logic [15:0] g;
        repeat (2) @(posedge clock);
        do_reset();
        chk("reset_oe", {31'd0, mdio_oe}, 32'd0);
        chk("reset_out", {31'd0, mdio_out}, 32'd1);

        // Write of 0xA5C3 to register 5.
        n = 0;
        push_frame(32, 1'b1, OP_WR, 5'd1, 5'd5, 16'hA5C3);
        for (int i = 0; i < 4; i++) push_bit(1'b1);
        run_segment();
        count_model(c_rd, c_wr, c_fe, c_oe);
        chk("wr_pulse_pos", {31'd0, e_wr[63]}, 32'd1);
        chk("wr_data_model", {16'd0, e_wdata[63]}, 32'h0000A5C3);
        chk("wr_addr_model", {27'd0, e_addr[63]}, 32'd5);
        chk("wr_count", c_wr, 32'd1);
        chk("wr_no_oe", c_oe, 32'd0);
        chk("wr_dut_wdata", {16'd0, reg_wdata}, 32'h0000A5C3);
        chk("wr_dut_addr", {27'd0, reg_address}, 32'd5);
        do_reset();

        // Read of register 2 returning 0xBEEF.
        n = 0; use_fixed = 1'b1; fixed_rd = 16'hBEEF;
        push_frame(32, 1'b1, OP_RD, 5'd1, 5'd2, 16'h0000);
        for (int i = 0; i < 4; i++) push_bit(1'b1);
        use_fixed = 1'b0;
        run_segment();
        count_model(c_rd, c_wr, c_fe, c_oe);
        for (int k = 0; k < 16; k++) g[15-k] = e_out[47+k];
        chk("rd_pulse_pos", {31'd0, e_rd[45]}, 32'd1);
        chk("rd_count", c_rd, 32'd1);
        chk("rd_ta_bit", {30'd0, e_oe[46], e_out[46]}, 32'd2);
        chk("rd_data_bits", {16'd0, g}, 32'h0000BEEF);
        chk("rd_oe_len", c_oe, 32'd17);
        chk("rd_oe_release", {31'd0, e_oe[63]}, 32'd0);
        do_reset();

        // PHY address mismatch.
        n = 0;
        push_frame(32, 1'b1, OP_RD, 5'd3, 5'd2, 16'h0000);
        for (int i = 0; i < 4; i++) push_bit(1'b1);
        run_segment();
        count_model(c_rd, c_wr, c_fe, c_oe);
        chk("phy_err_pos", {31'd0, e_ferr[40]}, 32'd1);
        chk("phy_err_strobes", c_rd + c_wr + c_oe, 32'd0);
        do_reset();

        // Short preamble is ignored; a long one is accepted.
        n = 0;
        push_frame(31, 1'b1, OP_WR, 5'd1, 5'd5, 16'hA5C3);
        run_segment();
        count_model(c_rd, c_wr, c_fe, c_oe);
        chk("short_pre_wr", c_wr, 32'd0);
        chk("short_pre_err", c_fe, 32'd0);
        do_reset();
        n = 0;
        push_frame(40, 1'b1, OP_WR, 5'd1, 5'd5, 16'hA5C3);
        for (int i = 0; i < 2; i++) push_bit(1'b1);
        run_segment();
        chk("long_pre_wr", {31'd0, e_wr[71]}, 32'd1);
        do_reset();

        // Bad opcode, then a valid frame with a fresh preamble.
        n = 0;
        push_frame(32, 1'b1, 2'b11, 5'd1, 5'd0, 16'h1234);
        push_frame(32, 1'b1, OP_WR, 5'd1, 5'd3, 16'h5A5A);
        for (int i = 0; i < 2; i++) push_bit(1'b1);
        run_segment();
        count_model(c_rd, c_wr, c_fe, c_oe);
        chk("op_err_pos", {31'd0, e_ferr[35]}, 32'd1);
        chk("op_err_then_wr", c_wr, 32'd1);
        do_reset();

        // Reset during data bit 8 of a read, then a normal write.
        n = 0;
        push_frame(32, 1'b1, OP_RD, 5'd1, 5'd7, 16'h0000);
        n = 56;
        run_segment();
        chk("mid_rd_oe_model", {30'd0, e_oe[55], e_busy[55]}, 32'd3);
        do_reset();
        chk("mid_rd_oe_after_reset", {30'd0, mdio_oe, busy}, 32'd0);
        n = 0;
        push_frame(32, 1'b1, OP_WR, 5'd1, 5'd9, 16'h1234);
        for (int i = 0; i < 4; i++) push_bit(1'b1);
        run_segment();
        chk("post_reset_wdata", {16'd0, reg_wdata}, 32'h00001234);
        chk("post_reset_addr", {27'd0, reg_address}, 32'd9);
        do_reset();

        for (int seg = 0; seg < 12; seg++) random_segment();

        @(negedge clock);
        mode = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- PHY-side (responder) end of the MDIO management interface, clocked directly by MDC.
- Decodes Clause-22 frames: preamble, ST=01, OP, PHYAD, REGAD, TA, 16-bit data.
- Write frames addressed to this PHY: issues a one-cycle write strobe to a local register file.
- Read frames: fetches register data and drives TA/data back onto MDIO through a separate output/enable pair; the pad tristate sits at top level.

Parameters:
PHY_ADDRESS, 5'd1, PHY address this responder answers to.
PREAMBLE_MIN, 32, consecutive 1 bits required before ST is accepted (1..63).
READ, 2'b10, opcode value for read.
WRITE, 2'b01, opcode value for write.

Ports:
clock  input  1  MDC; all logic on posedge.
reset  input  1  synchronous, active-high.
mdio_in  input  1  sampled MDIO line.
mdio_out  output  1  value driven on MDIO when mdio_oe=1.
mdio_oe  output  1  1 = responder drives MDIO.
reg_address  output  5  register address of the current frame.
reg_read  output  1  one-cycle read strobe.
reg_rdata  input  16  register data; must be valid in the cycle reg_read=1.
reg_write  output  1  one-cycle write strobe.
reg_wdata  output  16  write data; valid while reg_write=1 and held until the next write.
busy  output  1  1 from accepted ST until frame end.
frame_error  output  1  one-cycle pulse on bad ST, bad opcode or PHYAD mismatch.

Behaviour:
- mdio_in is sampled on posedge. All outputs are registered.
- Reset values: mdio_oe=0, mdio_out=1, reg_read=0, reg_write=0, reg_wdata=0, reg_address=0, busy=0, frame_error=0. Ones counter=0. State=HUNT.
- HUNT:
  - 6-bit ones counter increments on each sampled 1 and saturates at 63.
  - A sampled 0 clears the counter.
  - If a 0 is sampled while count>=PREAMBLE_MIN, it is taken as the ST first bit: go to START and set busy=1.
- START: sampled 1 -> OPCODE. Sampled 0 -> frame_error pulse, return to HUNT with counter=0.
- OPCODE: 2 bits, MSB first.
  - Value READ or WRITE is latched.
  - Value 00 or 11 -> frame_error, HUNT. The remaining frame bits are not decoded.
- PHY_ADDR: 5 bits, MSB first. At the posedge sampling the last bit, a mismatch with PHY_ADDRESS -> frame_error, HUNT. The responder never drives in this case.
- REG_ADDR: 5 bits, MSB first. reg_address is updated at the posedge sampling the last bit (P0). Go to TURNAROUND.
- Read timing, relative to P0 (Pn = n-th posedge after P0):
  - Set at P0: reg_read=1 for the cycle ending P1.
  - At P1: capture reg_rdata into the shift register; reg_read=0; mdio_oe=1; mdio_out=0 (TA second bit).
  - At P2..P17: mdio_out = D15..D0, one bit per posedge.
  - At P18: mdio_oe=0, mdio_out=1, busy=0; state HUNT with counter=0.
  - mdio_in is not sampled into the ones counter while mdio_oe=1.
- Write timing, relative to P0:
  - TA bits are sampled at P1 and P2 and not checked.
  - Data is sampled at P3..P18, MSB first.
  - At P18: reg_wdata=data; reg_write=1 for one cycle; busy=0; HUNT with counter=0.
- Back-to-back frames require a fresh preamble of at least PREAMBLE_MIN ones after the frame end.
- A 0 during HUNT below the threshold is not an error: no frame_error, counter cleared.
- Reset mid-frame:
  - Next cycle: mdio_oe=0 and no strobes.
  - Any partially received write is discarded.
- reg_read and reg_write are never both high, and each fires at most once per frame.

Test Plan:
- PHY_ADDRESS=1: 32 ones, then 01, 01, 00001, 00101, 10, 0xA5C3 -> one reg_write pulse 1 cycle after the last data bit; reg_address=5, reg_wdata=0xA5C3; mdio_oe stays 0.
- Read of reg 2 with reg_rdata=0xBEEF -> reg_read high exactly one cycle; mdio_oe rises 2 cycles after the last REGAD bit with mdio_out=0; then 16 cycles of 1011111011101111; then mdio_oe=0.
- Read with PHYAD=00011 -> frame_error pulse at the last PHYAD bit; no strobes; mdio_oe never asserts.
- 31 ones then a full valid write -> ignored, no strobes. Same write with 40 ones -> accepted.
- Opcode 11 -> frame_error; no strobes. A following valid frame with a new 32-bit preamble is accepted.
- Reset asserted at data bit 8 of a read -> mdio_oe=0 the next cycle, busy=0; the next valid write completes normally.
